// File: rtl/arb_pkg.sv
// Shared types and helpers for the four-master round-robin bus arbiter.
package arb_pkg;
   localparam int NUM_REQ = 4;
   localparam int SEL_W   = 2;

   typedef enum logic {IDLE, BUSY} arb_state_t;

   // First set request scanning ptr, ptr+1, ... with 2-bit wrap; offset 0 wins.
   function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                input logic [SEL_W-1:0]   ptr);
      logic [SEL_W-1:0] idx;
      rr_pick = ptr;
      for (int i = NUM_REQ-1; i >= 0; i--) begin
         idx = ptr + SEL_W'(i);
         if (req[idx]) rr_pick = idx;
      end
   endfunction
endpackage

// File: rtl/bus_arbiter_decoder.sv
// 2-to-4 one-hot decoder driving the arbiter's grant vector.
module Decoder
   import arb_pkg::*;
(
   input  logic [SEL_W-1:0]   i_sel,
   output logic [NUM_REQ-1:0] o_dec
);
   always_comb begin
      o_dec        = '0;
      o_dec[i_sel] = 1'b1;
   end
endmodule

// File: rtl/bus_arbiter.sv
// Four-requester round-robin arbiter with hold limit and one-cycle turnaround
// between owners; all outputs come from registers.
module bus_arbiter
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 8
)(
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [NUM_REQ-1:0] i_req,
   input  logic               i_done,
   output logic               o_grant_valid,
   output logic [SEL_W-1:0]   o_grant_sel,
   output logic [NUM_REQ-1:0] o_grant,
   output logic               o_timeout
);
   localparam int CNT_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
   // With no hold limit the counter just parks at 1.
   localparam logic [CNT_W-1:0] CNT_SAT = (MAX_HOLD == 0) ? CNT_W'(1) : CNT_W'(MAX_HOLD);

   arb_state_t         r_state;
   logic [SEL_W-1:0]   r_ptr;
   logic [SEL_W-1:0]   r_sel;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_timeout;
   logic               w_forced;
   logic               w_release;
   logic [NUM_REQ-1:0] w_dec;

   assign w_forced  = (MAX_HOLD != 0) && (r_cnt == CNT_SAT) && !i_done && i_req[r_sel];
   assign w_release = i_done || !i_req[r_sel] || w_forced;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= IDLE;
         r_ptr     <= '0;
         r_sel     <= '0;
         r_cnt     <= '0;
         r_timeout <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_timeout <= 1'b0;
               if (|i_req) begin
                  r_sel   <= rr_pick(i_req, r_ptr);
                  r_cnt   <= CNT_W'(1);
                  r_state <= BUSY;
               end
            end
            BUSY: begin
               if (w_release) begin
                  r_state   <= IDLE;
                  r_ptr     <= r_sel + SEL_W'(1);
                  r_cnt     <= '0;
                  r_timeout <= w_forced;
               end else begin
                  r_timeout <= 1'b0;
                  if (r_cnt != CNT_SAT) r_cnt <= r_cnt + CNT_W'(1);
               end
            end
         endcase
      end
   end

   Decoder u_dec (
      .i_sel (r_sel),
      .o_dec (w_dec)
   );

   assign o_grant_valid = (r_state == BUSY);
   assign o_grant_sel   = r_sel;
   assign o_grant       = w_dec & {NUM_REQ{o_grant_valid}};
   assign o_timeout     = r_timeout;
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: MAX_HOLD=8 instance plus an unlimited-hold instance.
module tb_bus_arbiter;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req, req0;
   logic       done, done0;
   logic       gv, to, gv0, to0;
   logic [1:0] sel, sel0;
   logic [3:0] g, g0;
   int         n_pass = 0;
   int         n_chk  = 0;

   always #5 clk = ~clk;

   bus_arbiter #(.MAX_HOLD(8)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_done(done),
      .o_grant_valid(gv), .o_grant_sel(sel), .o_grant(g), .o_timeout(to)
   );

   bus_arbiter #(.MAX_HOLD(0)) u_dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(req0), .i_done(done0),
      .o_grant_valid(gv0), .o_grant_sel(sel0), .o_grant(g0), .o_timeout(to0)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
   endtask

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_grant(input string tag, input logic [1:0] s);
      chk({tag, "_valid"}, {7'd0, gv}, 8'd1);
      chk({tag, "_sel"},   {6'd0, sel}, {6'd0, s});
      chk({tag, "_grant"}, {4'd0, g}, {4'd0, 4'b0001 << s});
   endtask

   task automatic chk_idle(input string tag, input logic t);
      chk({tag, "_valid"},   {7'd0, gv}, 8'd0);
      chk({tag, "_grant"},   {4'd0, g}, 8'd0);
      chk({tag, "_timeout"}, {7'd0, to}, {7'd0, t});
   endtask

   initial begin
      logic [1:0] exp_seq [5];
      exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

      // Reset with all masters requesting
      rst_n = 1'b0; req = 4'b1111; done = 1'b0; req0 = 4'b0000; done0 = 1'b0;
      #3;
      chk_idle("rst", 1'b0);
      chk("rst_sel", {6'd0, sel}, 8'd0);
      tick();
      chk_idle("rst_edge", 1'b0);
      rst_n = 1'b1;
      tick();

      // Rotation 0,1,2,3,0 with done on each owner's 2nd cycle
      for (int k = 0; k < 5; k++) begin
         chk_grant($sformatf("rot%0d", k), exp_seq[k]);
         tick();
         chk_grant($sformatf("rot%0d_c2", k), exp_seq[k]);
         done = 1'b1;
         tick();
         done = 1'b0;
         chk_idle($sformatf("rot%0d_ta", k), 1'b0);
         if (k == 4) req = 4'b0000;
         tick();
      end
      chk_idle("rot_end", 1'b0);

      // Single requester, hold limit of 8 cycles
      req = 4'b0100;
      tick();
      for (int i = 0; i < 8; i++) begin
         chk_grant($sformatf("hold%0d", i), 2'd2);
         chk($sformatf("hold%0d_to", i), {7'd0, to}, 8'd0);
         tick();
      end
      chk_idle("hold_rel", 1'b1);
      tick();
      chk_grant("hold_regrant", 2'd2);
      chk("hold_to_clr", {7'd0, to}, 8'd0);
      req = 4'b0000;
      tick();
      chk_idle("hold_wd", 1'b0);

      // Move pointer to 0: grant 3, release with done
      req = 4'b1000;
      tick();
      chk_grant("p3", 2'd3);
      done = 1'b1;
      tick();
      done = 1'b0;
      chk_idle("p3_rel", 1'b0);

      // Owner 1 withdraws; pointer 2 then skips to 3
      req = 4'b1010;
      tick();
      chk_grant("wd1", 2'd1);
      tick();
      req = 4'b1000;
      tick();
      chk_idle("wd1_rel", 1'b0);
      tick();
      chk_grant("wd_skip", 2'd3);
      done = 1'b1;
      tick();
      done = 1'b0;
      chk_idle("wd_skip_rel", 1'b0);

      // Asynchronous reset while owner 2 is busy
      req = 4'b0100;
      tick();
      chk_grant("ar_pre", 2'd2);
      #2 rst_n = 1'b0;
      #1;
      chk_idle("ar_now", 1'b0);
      req = 4'b0110;
      tick();
      rst_n = 1'b1;
      chk_idle("ar_held", 1'b0);
      tick();
      chk_grant("ar_ptr0", 2'd1);

      // done in IDLE with no requests
      req = 4'b0000;
      tick();
      chk_idle("di_rel", 1'b0);
      done = 1'b1;
      tick();
      done = 1'b0;
      chk_idle("di_done", 1'b0);
      tick();
      chk_idle("di_after", 1'b0);

      // Unlimited hold instance keeps its owner
      req0 = 4'b0001;
      tick();
      for (int i = 0; i < 20; i++) begin
         chk($sformatf("unl%0d_v", i), {7'd0, gv0}, 8'd1);
         chk($sformatf("unl%0d_g", i), {4'd0, g0}, 8'h01);
         chk($sformatf("unl%0d_to", i), {7'd0, to0}, 8'd0);
         tick();
      end
      req0 = 4'b0000;
      tick();
      chk("unl_rel", {7'd0, gv0}, 8'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
